// File: rtl/seq_div_unit.sv
// Multi-cycle radix-2 restoring divider: DIV/DIVU/REM/REMU and word forms, valid/ready on both sides, tag, flush.
// Optional build macro DIV_EARLY_OUT_EN: skip leading zeros of |dividend| (variable latency, identical results).
module seq_div_unit #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             div_sign,
    input  logic             div_w,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  quot,
    output logic [XLEN-1:0]  rem,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CW    = $clog2(XLEN) + 1;
    localparam bit HAS_W = (XLEN == 64);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          state, state_nx;
    logic            w_r, neg_q_r, neg_r_r;
    logic [XLEN-1:0] divisor_r, q_r, prem_r;
    logic [CW-1:0]   cnt, n_r;

    // Word ops take the low 32 bits and extend them (sign or zero) back to XLEN.
    function automatic logic [XLEN-1:0] ext_n(input logic [XLEN-1:0] v, input logic w, input logic s);
        logic [XLEN-1:0] r;
        r = v;
        if (w) begin
            for (int i = 32; i < XLEN; i++) r[i] = s & v[31];
        end
        return r;
    endfunction

    logic            accept, word_op, sign1, sign2, is_dbz, is_ovf, is_zero, special;
    logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_n, aligned, q_init;
    logic [CW-1:0]   n_in, cnt_init;
`ifdef DIV_EARLY_OUT_EN
    logic [CW-1:0]   lzc;
`endif

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        word_op = HAS_W & div_w;
        n_in    = word_op ? CW'(32) : CW'(XLEN);
        ext1    = ext_n(op1, word_op, div_sign);
        ext2    = ext_n(op2, word_op, div_sign);
        sign1   = div_sign & ext1[XLEN-1];
        sign2   = div_sign & ext2[XLEN-1];
        mag1    = sign1 ? -ext1 : ext1;
        mag2    = sign2 ? -ext2 : ext2;
        min_n   = XLEN'(1) << (n_in - CW'(1));
        is_dbz  = (ext2 == '0);
        is_ovf  = sign1 & (mag1 == min_n) & (ext2 == '1);
        // Left-align the N-bit magnitude so the iteration always starts from bit XLEN-1.
        aligned = word_op ? (mag1 << (XLEN - 32)) : mag1;
`ifdef DIV_EARLY_OUT_EN
        lzc = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (aligned[i]) lzc = CW'(XLEN - 1 - i);
        end
        is_zero  = (mag1 == '0);
        q_init   = aligned << lzc;
        cnt_init = lzc;
`else
        is_zero  = 1'b0;
        q_init   = aligned;
        cnt_init = '0;
`endif
        special = is_dbz | is_ovf | is_zero;
        accept  = in_valid & in_ready & ~flush;
    end

    logic [XLEN:0]   trial;
    logic            no_borrow;
    logic [XLEN-1:0] prem_nx, q_nx, quot_fix, rem_fix;

    always_comb begin
        n_r       = w_r ? CW'(32) : CW'(XLEN);
        trial     = {prem_r, q_r[XLEN-1]} - {1'b0, divisor_r};
        no_borrow = ~trial[XLEN];
        prem_nx   = no_borrow ? trial[XLEN-1:0] : {prem_r[XLEN-2:0], q_r[XLEN-1]};
        q_nx      = {q_r[XLEN-2:0], no_borrow};
        quot_fix  = ext_n(neg_q_r ? -q_r : q_r, w_r, 1'b1);
        rem_fix   = ext_n(neg_r_r ? -prem_r : prem_r, w_r, 1'b1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = special ? S_DONE : S_CALC;
            S_CALC:  if (cnt == n_r - CW'(1)) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // NOTE: datapath registers are reset along with the outputs; there is no array storage to leave uninitialised.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_r       <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            divisor_r <= '0;
            q_r       <= '0;
            prem_r    <= '0;
            cnt       <= '0;
            quot      <= '0;
            rem       <= '0;
            out_tag   <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    w_r       <= word_op;
                    neg_q_r   <= sign1 ^ sign2;
                    neg_r_r   <= sign1;
                    divisor_r <= mag2;
                    q_r       <= q_init;
                    prem_r    <= '0;
                    cnt       <= cnt_init;
                    out_tag   <= in_tag;
                    if (is_dbz) begin
                        quot <= '1;
                        rem  <= ext_n(op1, word_op, 1'b1);
                    end else if (is_ovf) begin
                        quot <= ext_n(op1, word_op, 1'b1);
                        rem  <= '0;
                    end else if (is_zero) begin
                        quot <= '0;
                        rem  <= '0;
                    end
                end
                S_CALC: begin
                    prem_r <= prem_nx;
                    q_r    <= q_nx;
                    cnt    <= cnt + CW'(1);
                end
                S_FIX: if (!flush) begin
                    quot <= quot_fix;
                    rem  <= rem_fix;
                end
                default: ;
            endcase
        end
    end
endmodule
